// File: rtl/game_turn_controller.sv
//==============================================================================
// Module      : game_turn_controller
// Description : Turn sequencer for a single-pile take-away game, human vs CPU.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module game_turn_controller #(
    parameter int PILE_INIT = 15,
    parameter int MAX_TAKE  = 3,
    parameter int CPU_DELAY = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] hMove,
    input  logic       enter,
    output logic [3:0] cMove,
    output logic [3:0] pile,
    output logic       humanTurn,
    output logic       illegal,
    output logic       win,
    output logic       lose
);

    localparam int                 THINK_W    = (CPU_DELAY > 1) ? $clog2(CPU_DELAY) : 1;
    localparam logic [THINK_W-1:0] THINK_LAST = THINK_W'(CPU_DELAY - 1);
    localparam logic [THINK_W-1:0] THINK_ONE  = THINK_W'(1);
    localparam logic [3:0]         PILE_RST   = 4'(PILE_INIT);
    localparam logic [3:0]         TAKE_MAX   = 4'(MAX_TAKE);
    localparam logic [3:0]         MODULUS    = 4'(MAX_TAKE + 1);

    typedef enum logic [1:0] {
        H_WAIT  = 2'd0,
        C_THINK = 2'd1,
        WIN     = 2'd2,
        LOSE    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         pile_q, pile_d;
    logic [3:0]         cmove_q, cmove_d;
    logic               illegal_q, illegal_d;
    logic               armed_q, armed_d;
    logic [THINK_W-1:0] think_q, think_d;

    logic               human_legal;
    logic [3:0]         cpu_rem;
    logic [3:0]         cpu_take;

    // Computer aims to leave a multiple of MAX_TAKE+1; takes one when it cannot.
    always_comb begin
        cpu_rem     = pile_q % MODULUS;
        cpu_take    = (cpu_rem == 4'd0) ? 4'd1 : cpu_rem;
        human_legal = (hMove != 4'd0) && (hMove <= TAKE_MAX) && (hMove <= pile_q);
    end

    always_comb begin
        state_d   = state_q;
        pile_d    = pile_q;
        cmove_d   = cmove_q;
        illegal_d = 1'b0;
        armed_d   = armed_q;
        think_d   = think_q;

        if (!enter) begin
            armed_d = 1'b1;
        end

        case (state_q)
            H_WAIT: begin
                if (enter && armed_q) begin
                    armed_d = 1'b0;
                    if (human_legal) begin
                        pile_d  = pile_q - hMove;
                        think_d = '0;
                        state_d = (hMove == pile_q) ? WIN : C_THINK;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            C_THINK: begin
                if (think_q == THINK_LAST) begin
                    cmove_d = cpu_take;
                    pile_d  = pile_q - cpu_take;
                    state_d = (cpu_take == pile_q) ? LOSE : H_WAIT;
                end else begin
                    think_d = think_q + THINK_ONE;
                end
            end
            default: begin
                // WIN / LOSE hold everything until reset.
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= H_WAIT;
            pile_q    <= PILE_RST;
            cmove_q   <= 4'd0;
            illegal_q <= 1'b0;
            armed_q   <= 1'b0;
            think_q   <= '0;
        end else begin
            state_q   <= state_d;
            pile_q    <= pile_d;
            cmove_q   <= cmove_d;
            illegal_q <= illegal_d;
            armed_q   <= armed_d;
            think_q   <= think_d;
        end
    end

    assign cMove     = cmove_q;
    assign pile      = pile_q;
    assign illegal   = illegal_q;
    assign humanTurn = (state_q == H_WAIT);
    assign win       = (state_q == WIN);
    assign lose      = (state_q == LOSE);

endmodule

`default_nettype wire

// File: doc/game_turn_controller.md
GAME_TURN_CONTROLLER -- requirements
Module: game_turn_controller

Interface
REQ-001 SHALL have parameter PILE_INIT, default 15, starting pile size (1..15).
REQ-002 SHALL have parameter MAX_TAKE, default 3, largest legal take per move (1..7).
REQ-003 SHALL have parameter CPU_DELAY, default 4, computer think time in cycles (>=1).
REQ-004 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port hMove  input  4  human take amount, unsigned.
REQ-007 SHALL have port enter  input  1  human commit request, level-sampled.
REQ-008 SHALL have port cMove  output  4  last computer take amount, registered.
REQ-009 SHALL have port pile  output  4  current pile count, registered.
REQ-010 SHALL have port humanTurn  output  1  high exactly while in H_WAIT.
REQ-011 SHALL have port illegal  output  1  one-cycle pulse on a rejected human move.
REQ-012 SHALL have port win  output  1  human took the last item; held until reset.
REQ-013 SHALL have port lose  output  1  computer took the last item; held until reset.

Function
REQ-014 SHALL implement states H_WAIT, C_THINK, WIN, LOSE.
REQ-015 SHALL keep an armed flag: set when enter is sampled low; cleared when a commit is sampled; one commit per enter assertion, however long enter is held.
REQ-016 In H_WAIT with enter=1 and armed=1, a move is legal iff 1 <= hMove <= min(MAX_TAKE, pile).
REQ-017 Legal move: at that edge pile <= pile - hMove; next state WIN if hMove == pile, else C_THINK with think counter cleared.
REQ-018 Illegal move: illegal=1 for the following cycle only; pile unchanged; state stays H_WAIT; armed cleared.
REQ-019 enter=1 with armed=0, or enter in any state other than H_WAIT: no effect, no illegal pulse.
REQ-020 C_THINK SHALL last exactly CPU_DELAY cycles; on its final edge the computer move is applied.
REQ-021 Computer take t = pile mod (MAX_TAKE+1); if t == 0 then t = 1; t never exceeds pile.
REQ-022 On applying: cMove <= t, pile <= pile - t; next state LOSE if t == pile, else H_WAIT.
REQ-023 WIN and LOSE SHALL be terminal: pile, cMove frozen, enter ignored, until reset.
REQ-024 win=1 exactly in WIN, lose=1 exactly in LOSE; never both.
REQ-025 All arithmetic SHALL be 4-bit unsigned; pile never underflows (guaranteed by REQ-016, REQ-021).
REQ-026 Human-commit-to-humanTurn latency SHALL be CPU_DELAY+1 cycles when the game does not end.

Reset
REQ-027 reset=1 at an edge SHALL force state H_WAIT, pile=PILE_INIT, cMove=0, illegal=0, win=0, lose=0, armed=0, think counter=0, overriding all other inputs.
REQ-028 Reset SHALL take effect from any state, including mid C_THINK and WIN/LOSE.
REQ-029 After reset, enter must be sampled low at least once before the first commit is accepted.

Verification (defaults 15/3/4)
REQ-030 Reset then release with enter=0 -> pile=15, cMove=0, humanTurn=1, win=lose=illegal=0.
REQ-031 hMove=2 one-cycle enter -> next cycle pile=13, humanTurn=0; 4 cycles later pile=12, cMove=1, humanTurn=1.
REQ-032 hMove=0, then hMove=4, then hMove=3 with pile=2 -> one-cycle illegal pulse each, pile unchanged, humanTurn stays 1.
REQ-033 enter held high 20 cycles with hMove=1 from pile=15 -> exactly one commit (pile=14, then computer cMove=2, pile=12); no second commit until enter drops and rises.
REQ-034 Human plays 3,3,3,3 from 15 -> computer takes 1,1,1 (piles 12,11,8,7,4,3) then human move leaves pile=0, win=1, held; later enter ignored.
REQ-035 Human plays 1 from 15 (cpu 2 -> 12), then 1,1,1 -> computer reaches pile=0 -> lose=1; also reset asserted mid C_THINK -> next cycle pile=15, H_WAIT, cMove=0.
